mult_rr_scheduler: RTL and testbench
====================================

Name: mult_rr_scheduler

Overview:
- Shares one registered signed multiplier among NUM_REQ requesters, e.g. matrix-multiply row engines contending for a single DSP slice.
- Arbitrates round-robin and issues one operand pair per cycle into the internal multiplier instance.
- Returns the product tagged with the requester ID on a valid/ready response channel.
- Sits between the matrix-multiply tile sequencers and the multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters; must be at least 2.
- DATA_WIDTH, 8, signed operand width.
- PRODUCT_WIDTH, 2*DATA_WIDTH, signed product width.
- ID_WIDTH, $clog2(NUM_REQ), requester tag width.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand-valid.
- req_a  input  NUM_REQ*DATA_WIDTH  packed signed operand A; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  input  NUM_REQ*DATA_WIDTH  packed signed operand B; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot or zero grant; a transfer happens when req_valid[i] && req_ready[i].
- resp_valid  output  1  product is valid.
- resp_ready  input  1  consumer accepts the product.
- resp_id  output  ID_WIDTH  index of the requester that owns resp_product.
- resp_product  output  PRODUCT_WIDTH  signed a*b.

Behaviour:
- Reset values: resp_valid=0, resp_id=0, resp_product=0, rr pointer=0. The internal multiplier is reset together with the block. req_ready is combinational and is 0 while reset is asserted.
- Output slot FSM has two states:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
  - EMPTY -> FULL on an issue. FULL -> EMPTY on resp_ready with no issue. FULL -> FULL on resp_ready with a simultaneous issue (back-to-back).
- Issue enable: can_issue = !resp_valid || resp_ready. The multiplier holds its product when not fed valid, so an issue must never overwrite an unconsumed result.
- Arbitration:
  - Combinational. When can_issue=1, grant the first i with req_valid[i]=1, searching from the rr pointer upward and wrapping modulo NUM_REQ.
  - req_ready is the grant vector. req_ready is all-zero when can_issue=0 or no request is pending.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- On an issue to requester g at edge t:
  - The multiplier captures a_g*b_g (multiplier valid=1) and resp_id<=g.
  - resp_valid=1 is visible after edge t, i.e. latency is 1 cycle.
  - rr pointer <= (g+1) mod NUM_REQ. The pointer is unchanged when no issue occurs.
- Stall: while resp_valid && !resp_ready, resp_product and resp_id hold stable and no grant is issued.
- Throughput: one product per cycle with resp_ready held high.
- Arithmetic: full-precision signed product with no truncation or saturation. Worst case (-2^(DW-1))^2 = 2^(2DW-2) fits.
- Fairness: a continuously requesting requester is granted within NUM_REQ issues.
- A requester that drops req_valid before being granted loses nothing; no request state is stored.
- Reset mid-operation: any in-flight or unconsumed product is discarded, resp_valid returns to 0 immediately (asynchronously), and the pointer returns to 0.
- resp_valid must not deassert without a resp_ready handshake (reset excepted).

Test Plan:
- Single request: req_valid=0001, a0=3, b0=-5 -> req_ready=0001 for 1 cycle; next cycle resp_valid=1, resp_id=0, resp_product=-15.
- Round-robin: req_valid=1111 held, resp_ready=1, operands a_i=i+1, b_i=2 -> grants 0,1,2,3,0 on consecutive cycles; products 2,4,6,8,2 with matching IDs.
- Backpressure: issue to requester 2 (a=7, b=7), then resp_ready=0 for 3 cycles with req_valid=1011 -> req_ready=0000 throughout; resp_product=49, resp_id=2 held stable. Releasing resp_ready grants requester 3 in the same cycle.
- Extremes: a=-128, b=-128 -> 16384 (0x4000); a=-128, b=127 -> -16256; a=0, b=-1 -> 0.
- Pointer skip: pointer=1, req_valid=1001 -> grant 3, pointer becomes 0, then grant 0.
- Reset mid-stall: resp_valid=1 with resp_ready=0, assert reset -> resp_valid, resp_id and resp_product go to 0 without waiting for clk. After release, req_valid=0011 grants requester 0 first.

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin sharing of one registered signed multiplier among NUM_REQ requesters
module mult_rr_mul #(
  parameter int DATA_WIDTH    = 8,
  parameter int PRODUCT_WIDTH = 2*DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic signed [DATA_WIDTH-1:0]    a,
  input  logic signed [DATA_WIDTH-1:0]    b,
  output logic signed [PRODUCT_WIDTH-1:0] product
);
  always_ff @(posedge clk or posedge reset)
    if (reset) product <= '0;
    else if (in_valid) product <= a * b;
endmodule

module mult_rr_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int PRODUCT_WIDTH = 2*DATA_WIDTH,
  parameter int ID_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [ID_WIDTH-1:0]           resp_id,
  output logic [PRODUCT_WIDTH-1:0]      resp_product
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_n;
  logic [ID_WIDTH-1:0] ptr, ptr_n, gnt;
  logic found, can_issue, issue;
  logic signed [DATA_WIDTH-1:0] op_a, op_b;
  logic signed [PRODUCT_WIDTH-1:0] product;
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt = ID_WIDTH'(idx);
      end
    end
  end
  assign resp_valid = state == FULL;
  assign can_issue  = !resp_valid || resp_ready;
  assign issue      = found && can_issue && !reset;
  assign req_ready  = issue ? NUM_REQ'(1) << gnt : '0;
  assign op_a = req_a[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
  assign op_b = req_b[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
  always_comb begin
    state_n = issue ? FULL : (resp_valid && resp_ready) ? EMPTY : state;
    ptr_n = !issue ? ptr : (int'(gnt) == NUM_REQ-1) ? '0 : gnt + ID_WIDTH'(1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= EMPTY;
      ptr     <= '0;
      resp_id <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      if (issue) resp_id <= gnt;
    end
  mult_rr_mul #(.DATA_WIDTH(DATA_WIDTH), .PRODUCT_WIDTH(PRODUCT_WIDTH)) u_mul (
    .clk(clk),
    .reset(reset),
    .in_valid(issue),
    .a(op_a),
    .b(op_b),
    .product(product)
  );
  assign resp_product = product;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler: directed checks of arbitration, latency, backpressure, extremes and async reset
module tb_mult_rr_scheduler;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req_valid;
  logic [31:0] req_a, req_b;
  logic [3:0] req_ready;
  logic resp_valid, resp_ready;
  logic [1:0] resp_id;
  logic [15:0] resp_product;
  int checks = 0;
  int failures = 0;
  mult_rr_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_resp(input string tag, input int v, input int id, input int p);
    chk({tag, "_valid"}, int'(resp_valid), v);
    chk({tag, "_id"}, int'(resp_id), id);
    chk({tag, "_product"}, int'($signed(resp_product)), p);
  endtask
  task automatic set_op(input int i, input int a, input int b);
    req_a[i*8 +: 8] = 8'(a);
    req_b[i*8 +: 8] = 8'(b);
  endtask
  initial begin
    reset = 1'b1; req_valid = 4'b0001; req_a = '0; req_b = '0; resp_ready = 1'b0;
    #3;
    chk_resp("reset", 0, 0, 0);
    chk("reset_ready", int'(req_ready), 0);
    @(negedge clk); reset = 1'b0;
    // single request
    set_op(0, 3, -5); req_valid = 4'b0001; resp_ready = 1'b1;
    #1 chk("single_ready", int'(req_ready), 1);
    @(negedge clk); req_valid = 4'b0000;
    chk_resp("single", 1, 0, -15);
    #1 chk("single_idle_ready", int'(req_ready), 0);
    @(negedge clk);
    chk("drain_valid", int'(resp_valid), 0);
    // pointer skip with extremes: ptr=1
    set_op(3, -128, -128); set_op(0, -128, 127); req_valid = 4'b1001;
    #1 chk("skip_ready3", int'(req_ready), 8);
    @(negedge clk);
    chk_resp("ext_max", 1, 3, 16384);
    #1 chk("skip_ready0", int'(req_ready), 1);
    @(negedge clk);
    chk_resp("ext_mix", 1, 0, -16256);
    set_op(0, 0, -1); req_valid = 4'b0001;
    @(negedge clk);
    chk_resp("ext_zero", 1, 0, 0);
    // backpressure: ptr=1
    set_op(2, 7, 7); req_valid = 4'b0100;
    #1 chk("bp_ready2", int'(req_ready), 4);
    @(negedge clk); resp_ready = 1'b0; req_valid = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      #1 chk("bp_stall_ready", int'(req_ready), 0);
      chk_resp("bp_hold", 1, 2, 49);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1 chk("bp_release_ready", int'(req_ready), 8);
    @(negedge clk);
    chk_resp("bp_after", 1, 3, 16384);
    // round robin from ptr=0
    for (int i = 0; i < 4; i++) set_op(i, i + 1, 2);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_ready", int'(req_ready), 1 << (k % 4));
      @(negedge clk);
      chk_resp("rr_resp", 1, k % 4, 2 * (k % 4 + 1));
    end
    // reset mid-stall
    req_valid = 4'b0000; resp_ready = 1'b0;
    @(negedge clk);
    chk("stall_valid", int'(resp_valid), 1);
    #2 reset = 1'b1; req_valid = 4'b0011;
    #1 chk_resp("async_reset", 0, 0, 0);
    chk("async_reset_ready", int'(req_ready), 0);
    @(negedge clk); reset = 1'b0; resp_ready = 1'b1;
    #1 chk("post_reset_ready", int'(req_ready), 1);
    @(negedge clk); req_valid = 4'b0000;
    chk_resp("post_reset", 1, 0, 2);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
